// File: rtl/sync_pkg.sv
// Shared constants and helpers for the input-conditioning blocks.
// Latency: n/a (package only).
// Backpressure: n/a; every user of these defaults ends up with the same synchronizer depth and filter setting.
package sync_pkg;

    // Three flops keep MTBF comfortable at typical core clock rates.
    localparam int SYNC_STAGES_DEFAULT   = 3;
    // Filtering is opt-in; plain synchronization is the common case.
    localparam int FILTER_CYCLES_DEFAULT = 0;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Debounce counter width. It counts 0..F-1 and never needs fewer than one bit.
    function automatic int cnt_width(input int filter_cycles);
        return (clog2(filter_cycles) < 1) ? 1 : clog2(filter_cycles);
    endfunction

endpackage

// File: rtl/sync_debounce_if.sv
// Bundles the per-channel level and strobe signals of the input conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; data_i is sampled every cycle and the outputs are plain registered levels and strobes.
//   data_i : asynchronous inputs, driven by the master side
//   data_o : synchronized, filtered level
//   rise_o : one-cycle strobe when data_o goes 0->1
//   fall_o : one-cycle strobe when data_o goes 1->0
interface sync_debounce_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;

    // Master drives the asynchronous inputs and consumes the conditioned result.
    modport master (
        output data_i,
        input  data_o,
        input  rise_o,
        input  fall_o
    );

    // Slave is the conditioner itself.
    modport slave (
        input  data_i,
        output data_o,
        output rise_o,
        output fall_o
    );
endinterface

// File: rtl/sync_debounce_channel.sv
// Single-channel pulse filter: the level only follows a candidate that has differed from it for F consecutive cycles.
// Latency: F cycles from the candidate change to the level/strobe change, with level and strobes registered together.
// Backpressure: none; the candidate is evaluated every cycle.
//   clk, reset : clock and synchronous active-high reset
//   cand       : synchronized candidate level (the last sync-chain stage)
//   level      : filtered level register
//   rise, fall : one-cycle strobes, high in the cycle that level shows its new value
module debounce_channel
    import sync_pkg::*;
#(
    parameter int   F         = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic cand,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW   = cnt_width(F);
    localparam logic [CW-1:0]  LAST = CW'(F - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_q;
    logic          level_next;
    logic          rise_q;
    logic          fall_q;

    // The counter runs only while the candidate disagrees with the level.
    // Any return to the level value clears it, so a change has to persist
    // for F uninterrupted cycles before it is accepted.
    always_comb begin
        level_next = level_q;
        cnt_next   = '0;
        if (cand != level_q) begin
            if (cnt == LAST) begin
                level_next = cand;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Strobes come from the same next-state term as the level, so they are
    // aligned with the new level and cannot both be high at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= RESET_VAL;
            cnt     <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_next;
            cnt     <= cnt_next;
            rise_q  <= level_next & ~level_q;
            fall_q  <= ~level_next & level_q;
        end
    end

`ifdef FORMAL
    initial begin
        level_q = RESET_VAL;
        cnt     = '0;
        rise_q  = 1'b0;
        fall_q  = 1'b0;
    end
`endif

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel conditioner for asynchronous inputs: a STAGES-deep synchronizer, an optional per-channel pulse filter, and rise/fall strobes.
// Latency: STAGES cycles unfiltered, STAGES+FILTER_CYCLES filtered; all outputs are registered.
// Backpressure: none; the inputs are sampled every cycle and the outputs are free-running levels and strobes.
//   clk, reset : clock and synchronous active-high reset
//   bus        : sync_debounce_if slave (data_i in; data_o, rise_o, fall_o out)
// Channels are independent of each other, so a multi-bit bus has to be Gray coded before it reaches this block.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = SYNC_STAGES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_STATE   = '0,
    parameter int               FILTER_CYCLES = FILTER_CYCLES_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    sync_debounce_if.slave bus
);

    // Fewer than two flops offers no metastability protection.
    if (STAGES < 2) begin : g_stages_check
        $error("sync_debounce: STAGES must be at least 2");
    end

    // sync_q[0] samples the pins; sync_q[STAGES-1] is the candidate level.
    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_STATE;
            end
        end else begin
            sync_q[0] <= bus.data_i;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

`ifdef FORMAL
    initial begin
        for (int k = 0; k < STAGES; k++) begin
            sync_q[k] = RESET_STATE;
        end
    end
`endif

    if (FILTER_CYCLES == 0) begin : g_bypass
        // The candidate register is the output level. Its next value is
        // the stage before it, which lets the strobes land in the same
        // cycle as the level change.
        logic [WIDTH-1:0] rise_q;
        logic [WIDTH-1:0] fall_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rise_q <= '0;
                fall_q <= '0;
            end else begin
                rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
                fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
            end
        end

`ifdef FORMAL
        initial begin
            rise_q = '0;
            fall_q = '0;
        end
`endif

        assign bus.data_o = sync_q[STAGES-1];
        assign bus.rise_o = rise_q;
        assign bus.fall_o = fall_q;
    end else begin : g_filter
        logic [WIDTH-1:0] level_w;
        logic [WIDTH-1:0] rise_w;
        logic [WIDTH-1:0] fall_w;

        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            debounce_channel #(
                .F         (FILTER_CYCLES),
                .RESET_VAL (RESET_STATE[i])
            ) u_ch (
                .clk   (clk),
                .reset (reset),
                .cand  (sync_q[STAGES-1][i]),
                .level (level_w[i]),
                .rise  (rise_w[i]),
                .fall  (fall_w[i])
            );
        end

        assign bus.data_o = level_w;
        assign bus.rise_o = rise_w;
        assign bus.fall_o = fall_w;
    end

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    int total = 0;
    int bad   = 0;

    // u0: reset values and unfiltered latency
    sync_debounce_if #(.WIDTH(4)) if0 ();
    sync_debounce #(.WIDTH(4), .STAGES(3), .RESET_STATE(4'b1010), .FILTER_CYCLES(0))
        u0 (.clk(clk), .reset(rst_a), .bus(if0));

    // u1: filtered latency (bit 1) and glitch rejection (bit 0)
    sync_debounce_if #(.WIDTH(2)) if1 ();
    sync_debounce #(.WIDTH(2), .STAGES(2), .RESET_STATE(2'b10), .FILTER_CYCLES(4))
        u1 (.clk(clk), .reset(rst_a), .bus(if1));

    // u2: reset in the middle of a count
    sync_debounce_if #(.WIDTH(1)) if2 ();
    sync_debounce #(.WIDTH(1), .STAGES(2), .RESET_STATE(1'b0), .FILTER_CYCLES(8))
        u2 (.clk(clk), .reset(rst_b), .bus(if2));

    // u3: random toggles on all channels against a window-based reference
    sync_debounce_if #(.WIDTH(8)) if3 ();
    sync_debounce #(.WIDTH(8), .STAGES(3), .RESET_STATE(8'h00), .FILTER_CYCLES(3))
        u3 (.clk(clk), .reset(rst_a), .bus(if3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference state for u3. The model keeps the last 3 candidate samples
    // and flips a bit when all three disagree with the current level.
    logic [7:0] m_sh [3];
    logic [7:0] m_hist [3];
    logic [7:0] m_lvl;
    logic [7:0] m_rise;
    logic [7:0] m_fall;
    logic [7:0] nl;

    initial begin
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        if0.data_i = 4'b1010;
        if1.data_i = 2'b10;
        if2.data_i = 1'b0;
        if3.data_i = 8'h00;

        // Reset values: 5 cycles in reset, then release with matching inputs
        for (int c = 1; c <= 5; c++) begin
            step();
            check("rst_data", 32'(if0.data_o), 32'(4'b1010));
            check("rst_rise", 32'(if0.rise_o), 32'd0);
            check("rst_fall", 32'(if0.fall_o), 32'd0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("rel_data", 32'(if0.data_o), 32'(4'b1010));
            check("rel_rise", 32'(if0.rise_o), 32'd0);
            check("rel_fall", 32'(if0.fall_o), 32'd0);
            check("rel_u1_data", 32'(if1.data_o), 32'(2'b10));
            check("rel_u1_strobe", 32'(if1.rise_o | if1.fall_o), 32'd0);
        end

        // Unfiltered latency: STAGES=3, bit 0 rises before posedge 1
        if0.data_i = 4'b1011;
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("unf_data_c%0d", c), 32'(if0.data_o[0]), 32'(c >= 3));
            check($sformatf("unf_rise_c%0d", c), 32'(if0.rise_o[0]), 32'(c == 3));
            check($sformatf("unf_fall_c%0d", c), 32'(if0.fall_o[0]), 32'd0);
        end

        // Filtered latency: STAGES=2, F=4, bit 1 falls before posedge 1
        if1.data_i = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("flt_data_c%0d", c), 32'(if1.data_o[1]), 32'(c < 6));
            check($sformatf("flt_fall_c%0d", c), 32'(if1.fall_o[1]), 32'(c == 6));
            check($sformatf("flt_rise_c%0d", c), 32'(if1.rise_o[1]), 32'd0);
        end

        // Glitch of 3 cycles on bit 0: rejected
        for (int c = 1; c <= 12; c++) begin
            if1.data_i = {1'b0, (c <= 3) ? 1'b1 : 1'b0};
            step();
            check($sformatf("g3_data_c%0d", c), 32'(if1.data_o[0]), 32'd0);
            check($sformatf("g3_strobe_c%0d", c), 32'({if1.rise_o[0], if1.fall_o[0]}), 32'd0);
        end

        // Pulse of exactly 4 cycles: accepted, rise at 6, fall at 10
        for (int c = 1; c <= 14; c++) begin
            if1.data_i = {1'b0, (c <= 4) ? 1'b1 : 1'b0};
            step();
            check($sformatf("g4_data_c%0d", c), 32'(if1.data_o[0]), 32'(c >= 6 && c < 10));
            check($sformatf("g4_rise_c%0d", c), 32'(if1.rise_o[0]), 32'(c == 6));
            check($sformatf("g4_fall_c%0d", c), 32'(if1.fall_o[0]), 32'(c == 10));
        end

        // Mid-count reset on u2 (F=8): cnt reaches 5 after posedge 7
        if2.data_i = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            check($sformatf("mc_pre_c%0d", c), 32'(if2.data_o), 32'd0);
        end
        rst_b = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            step();
            check("mc_rst_data", 32'(if2.data_o), 32'd0);
            check("mc_rst_strobe", 32'({if2.rise_o, if2.fall_o}), 32'd0);
        end
        rst_b = 1'b0;
        // Two sync stages plus a full 8-cycle qualification after release
        for (int r = 1; r <= 12; r++) begin
            step();
            check($sformatf("mc_post_data_r%0d", r), 32'(if2.data_o), 32'(r >= 10));
            check($sformatf("mc_post_rise_r%0d", r), 32'(if2.rise_o), 32'(r == 10));
            check($sformatf("mc_post_fall_r%0d", r), 32'(if2.fall_o), 32'd0);
        end

        // Random independent toggles on u3; its inputs have been 0 since reset
        for (int k = 0; k < 3; k++) begin
            m_sh[k]   = 8'h00;
            m_hist[k] = 8'h00;
        end
        m_lvl  = 8'h00;
        m_rise = 8'h00;
        m_fall = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            check("rnd_data", 32'(if3.data_o), 32'(m_lvl));
            check("rnd_rise", 32'(if3.rise_o), 32'(m_rise));
            check("rnd_fall", 32'(if3.fall_o), 32'(m_fall));
            check("rnd_excl", 32'(if3.rise_o & if3.fall_o), 32'd0);

            if3.data_i = if3.data_i ^ 8'($urandom & $urandom & $urandom);

            // Model of the coming posedge
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = m_sh[2];
            for (int b = 0; b < 8; b++) begin
                if (m_hist[0][b] != m_lvl[b] && m_hist[1][b] != m_lvl[b] &&
                    m_hist[2][b] != m_lvl[b])
                    nl[b] = ~m_lvl[b];
                else
                    nl[b] = m_lvl[b];
            end
            m_rise = nl & ~m_lvl;
            m_fall = ~nl & m_lvl;
            m_lvl  = nl;
            m_sh[2] = m_sh[1];
            m_sh[1] = m_sh[0];
            m_sh[0] = if3.data_i;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Parametrised multi-channel input conditioner: brings WIDTH asynchronous signals into the clk domain through a configurable-depth flop chain, then optionally rejects pulses shorter than FILTER_CYCLES per channel. It also produces registered one-cycle rise and fall strobes. It replaces fixed three-flop synchronizers at every asynchronous input boundary: FIFO pointers excluded, buttons, external status lines and interrupt pins included.

## Interface
- WIDTH, 1, number of independent channels (≥1)
- STAGES, 3, synchronizer flops per channel before the filter (≥2; <2 is an elaboration error)
- RESET_STATE, 0, reset value of sync chain and data_o; bit i applies to channel i
- FILTER_CYCLES, 0, consecutive cycles a new level must persist before data_o follows; 0 = filter bypassed
- clk  input  1  clock; all logic on posedge
- reset  input  1  reset, synchronous, active-high
- data_i  input  WIDTH  asynchronous inputs
- data_o  output  WIDTH  synchronized and filtered level
- rise_o  output  WIDTH  one-cycle strobe, data_o[i] went 0→1 this cycle
- fall_o  output  WIDTH  one-cycle strobe, data_o[i] went 1→0 this cycle

## Operation
- Sync chain: STAGES flops per channel; stage 0 samples data_i, stage k samples stage k-1. The last stage is the candidate.
- FILTER_CYCLES = 0: data_o is the candidate register itself; no counter is instantiated.
- FILTER_CYCLES = F ≥ 1: each channel has a counter cnt, width max(1, clog2(F)).
  - candidate == data_o: cnt ← 0.
  - candidate != data_o and cnt == F-1: data_o ← candidate, cnt ← 0.
  - Otherwise: cnt ← cnt + 1.
- Any excursion shorter than F consecutive cycles at the candidate is discarded. The counter restarts on every return to the data_o value.
- Strobes: rise_o[i] ← data_o_next[i] & ~data_o[i]; fall_o[i] ← ~data_o_next[i] & data_o[i]. Both are registered with data_o, so a strobe is high in exactly the cycle data_o shows the new value. rise_o and fall_o of one channel are never high together.
- Channels are fully independent; there is no cross-channel coherence guarantee. Multi-bit buses need Gray coding upstream.
- Reset:
  - Chain and data_o ← RESET_STATE; cnt ← 0; rise_o, fall_o ← 0.
  - Reset never produces a strobe, including on the first cycle after deassertion.
  - Reset mid-count discards the pending change.
- FORMAL builds initialise all state to the reset values.

## Timing
- data_i changes and is stable from before posedge 1: the candidate changes after posedge STAGES.
- Unfiltered: data_o and the strobe update after posedge STAGES.
- Filtered: data_o and the strobe update after posedge STAGES+F.
- Minimum accepted pulse at the candidate is F cycles. A level held exactly F cycles updates data_o. A level held F-1 cycles does not.
- Back-to-back opposite edges are each strobed if each level persists ≥ max(1,F) cycles. The strobes are then at least max(1,F) cycles apart.
- No combinational path from any input to any output.

## Structure
- Shared package sync_pkg:
  - clog2 helper function.
  - Default constants SYNC_STAGES_DEFAULT = 3 and FILTER_CYCLES_DEFAULT = 0, so all instances agree on defaults.
- Sub-module debounce_channel: one channel's counter, level register and strobe flops, parametrised by F.
  - Instantiated WIDTH times under a generate, only when FILTER_CYCLES ≥ 1.
- Sync chain stays in the top module as a STAGES×WIDTH register array.

## Test plan
- Reset values: WIDTH=4, RESET_STATE=4'b1010, hold reset 5 cycles then release with data_i=4'b1010 → data_o=4'b1010 and rise_o/fall_o=0 throughout, including the release cycle.
- Latency, unfiltered: STAGES=3, F=0, data_i[0] 0→1 before posedge 1 → data_o[0]=1 and rise_o[0]=1 after posedge 3 only; rise_o[0]=0 one cycle later.
- Latency, filtered: STAGES=2, F=4, data_i[1] 1→0 held → fall_o[1] pulses once, data_o[1]=0 after posedge 6.
- Glitch rejection: F=4, candidate high for exactly 3 cycles then low → data_o unchanged, no strobe. Repeat with exactly 4 cycles → rise_o then fall_o, 4 cycles apart.
- Mid-count reset: F=8, reset asserted when cnt=5 → data_o=RESET_STATE, no strobe. After release a fresh 8-cycle qualification is required.
- Channel independence: WIDTH=8, random asynchronous toggles on all bits for 10k cycles → each channel's data_o and strobes match a per-bit reference model. rise_o & fall_o == 0 every cycle.
